// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared grid dimensions, scheduler state encoding and one-hot value type.
`ifndef GRID_LEN
`define GRID_LEN 4
`endif
package sudoku_pkg;
    localparam int IDX_W = $clog2(`GRID_LEN);
    typedef logic [`GRID_LEN-1:0] onehot_t;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GRANT,
        S_WAIT,
        S_EXIT_F,
        S_EXIT_B
    } sched_state_e;
endpackage

// File: rtl/prefix_or_mask.sv
// prefix_or_mask: OR of the one-hot values of every tile left of the active index.
module prefix_or_mask import sudoku_pkg::*; #(
    parameter int LEN = `GRID_LEN
) (
    input  logic [LEN*LEN-1:0]     tile_value,
    input  logic [$clog2(LEN)-1:0] idx,
    output logic [LEN-1:0]         mask
);
    localparam int IW = $clog2(LEN);
    always_comb begin
        mask = '0;
        for (int j = 0; j < LEN; j++)
            if (IW'(j) < idx) mask = mask | tile_value[j*LEN +: LEN];
    end
endmodule

// File: rtl/row_turn_scheduler.sv
// row_turn_scheduler: walks the backtracking turn token across the tiles of one grid row.
module row_turn_scheduler import sudoku_pkg::*; #(
    parameter int LEN     = `GRID_LEN,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start_fwd,
    input  logic                   start_bak,
    input  logic [LEN-1:0]         col_mask,
    input  logic [LEN*LEN-1:0]     tile_value,
    input  logic [LEN-1:0]         tile_passfwd,
    input  logic [LEN-1:0]         tile_passbak,
    output logic [LEN-1:0]         tile_myturn,
    output logic [LEN-1:0]         occupiedmask,
    output logic [$clog2(LEN)-1:0] cur_index,
    output logic                   row_passfwd,
    output logic                   row_passbak,
    output logic                   busy,
    output logic                   stall,
    output logic                   proto_err
);
    localparam int IW = $clog2(LEN);
    localparam int CW = $clog2(TIMEOUT + 1);
    sched_state_e r_state, w_next;
    logic [IW-1:0]  r_idx, w_idx_next;
    logic [LEN-1:0] r_mask, r_myturn, w_sel, w_pmask;
    logic [CW-1:0]  r_cnt;
    logic           r_pf, r_pb, r_stall, r_err;
    logic           w_fwd, w_bak, w_stray, w_err;
    prefix_or_mask #(.LEN(LEN)) u_prefix (
        .tile_value(tile_value),
        .idx       (r_idx),
        .mask      (w_pmask)
    );
    assign w_sel   = LEN'(1) << r_idx;
    assign w_fwd   = |(tile_passfwd & w_sel);
    assign w_bak   = |(tile_passbak & w_sel);
    assign w_stray = |((tile_passfwd | tile_passbak) & ~w_sel);
    assign w_err   = (r_state == S_IDLE ? (start_fwd & start_bak) : (start_fwd | start_bak))
                   | (r_state == S_WAIT & ((w_fwd & w_bak) | w_stray));
    always_comb begin
        w_next     = r_state;
        w_idx_next = r_idx;
        case (r_state)
            S_IDLE: begin
                if (start_bak) begin
                    w_next     = S_LOAD;
                    w_idx_next = IW'(LEN - 1);
                end else if (start_fwd) begin
                    w_next     = S_LOAD;
                    w_idx_next = '0;
                end
            end
            S_LOAD:  w_next = S_GRANT;
            S_GRANT: w_next = S_WAIT;
            S_WAIT: begin
                // backtrack wins when the active tile raises both passes
                if (w_bak) begin
                    w_next     = (r_idx == '0) ? S_EXIT_B : S_LOAD;
                    w_idx_next = (r_idx == '0) ? r_idx : r_idx - IW'(1);
                end else if (w_fwd) begin
                    w_next     = (r_idx == IW'(LEN - 1)) ? S_EXIT_F : S_LOAD;
                    w_idx_next = (r_idx == IW'(LEN - 1)) ? r_idx : r_idx + IW'(1);
                end
            end
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_mask   <= '0;
            r_myturn <= '0;
            r_cnt    <= '0;
            r_pf     <= 1'b0;
            r_pb     <= 1'b0;
            r_stall  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_idx    <= w_idx_next;
            r_mask   <= (r_state == S_LOAD) ? (col_mask | w_pmask) : r_mask;
            r_myturn <= (r_state == S_LOAD) ? w_sel : '0;
            r_pf     <= (r_state == S_EXIT_F);
            r_pb     <= (r_state == S_EXIT_B);
            r_cnt    <= (r_state == S_WAIT && w_next == S_WAIT)
                      ? ((r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + CW'(1)) : '0;
            r_stall  <= r_stall | (r_cnt == CW'(TIMEOUT));
            r_err    <= r_err | w_err;
        end
    end
    assign tile_myturn  = r_myturn;
    assign occupiedmask = r_mask;
    assign cur_index    = r_idx;
    assign row_passfwd  = r_pf;
    assign row_passbak  = r_pb;
    assign busy         = (r_state != S_IDLE);
    assign stall        = r_stall;
    assign proto_err    = r_err;
endmodule

// File: tb/tb_row_turn_scheduler.sv
// tb_row_turn_scheduler: scoreboard bench; grant/row-pass events are queued with their due cycle.
module tb_row_turn_scheduler;
    import sudoku_pkg::*;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_fwd = 1'b0, start_bak = 1'b0;
    onehot_t     col_mask = '0;
    logic [15:0] tile_value = '0;
    onehot_t     tile_passfwd = '0, tile_passbak = '0;
    onehot_t     tile_myturn, occupiedmask;
    logic [1:0]  cur_index;
    logic        row_passfwd, row_passbak, busy, stall, proto_err;
    typedef struct { logic [5:0] ev; int cyc; } exp_t;
    exp_t q[$];
    int   cyc = 0;
    int   vec = 0;
    int   errs = 0;
    row_turn_scheduler #(.LEN(4), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .start_fwd(start_fwd), .start_bak(start_bak),
        .col_mask(col_mask), .tile_value(tile_value), .tile_passfwd(tile_passfwd),
        .tile_passbak(tile_passbak), .tile_myturn(tile_myturn), .occupiedmask(occupiedmask),
        .cur_index(cur_index), .row_passfwd(row_passfwd), .row_passbak(row_passbak),
        .busy(busy), .stall(stall), .proto_err(proto_err)
    );
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    // every visible event {row_passfwd,row_passbak,tile_myturn} must match the queue head
    always @(negedge clock) begin
        exp_t e;
        if (!reset && (tile_myturn != '0 || row_passfwd || row_passbak)) begin
            vec++;
            if (q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_event got=%b at cycle %0d required=none",
                         {row_passfwd, row_passbak, tile_myturn}, cyc);
            end else begin
                e = q.pop_front();
                if ({row_passfwd, row_passbak, tile_myturn} !== e.ev || cyc != e.cyc) begin
                    errs++;
                    $display("FAIL event got=%b@%0d required=%b@%0d",
                             {row_passfwd, row_passbak, tile_myturn}, cyc, e.ev, e.cyc);
                end
            end
        end
    end
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask
    task automatic drive(input logic [3:0] pf, input logic [3:0] pb, input logic sf,
                         input logic sb, input logic [5:0] ev, input int wait_after);
        if (ev != '0) q.push_back('{ev, cyc + 2});
        tile_passfwd = pf; tile_passbak = pb; start_fwd = sf; start_bak = sb;
        step(1);
        tile_passfwd = '0; tile_passbak = '0; start_fwd = 1'b0; start_bak = 1'b0;
        step(wait_after);
    endtask
    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
    endtask
    task automatic test_reset();
        step(2);
        vec++;
        if ({tile_myturn, occupiedmask, cur_index, row_passfwd, row_passbak, busy, stall, proto_err} !== '0) begin
            errs++;
            $display("FAIL reset_init got=%b required=0",
                     {tile_myturn, occupiedmask, cur_index, row_passfwd, row_passbak, busy, stall, proto_err});
        end
        reset = 1'b0;
        step(1);
        drive(4'b0000, 4'b0000, 1, 0, 6'b000001, 3);
        drive(4'b0001, 4'b0000, 0, 0, 6'b000010, 3);
        drive(4'b0010, 4'b0000, 0, 0, 6'b000100, 4);
        vec++;
        if (cur_index !== 2'd2 || !busy) begin
            errs++;
            $display("FAIL pre_reset_idx got=%0d busy=%b required=2 busy=1", cur_index, busy);
        end
        reset = 1'b1;
        step(1);
        vec++;
        if ({tile_myturn, occupiedmask, cur_index, row_passfwd, row_passbak, busy, stall, proto_err} !== '0) begin
            errs++;
            $display("FAIL reset_midwait got=%b required=0",
                     {tile_myturn, occupiedmask, cur_index, row_passfwd, row_passbak, busy, stall, proto_err});
        end
        reset = 1'b0;
        step(4);
        vec++;
        if (q.size() != 0 || busy) begin
            errs++;
            $display("FAIL reset_leftover pending=%0d busy=%b required=0 0", q.size(), busy);
        end
        q.delete();
    endtask
    task automatic test_forward();
        drive(4'b0000, 4'b0000, 1, 0, 6'b000001, 3);
        drive(4'b0001, 4'b0000, 0, 0, 6'b000010, 3);
        drive(4'b0010, 4'b0000, 0, 0, 6'b000100, 3);
        drive(4'b0100, 4'b0000, 0, 0, 6'b001000, 3);
        drive(4'b1000, 4'b0000, 0, 0, 6'b100000, 4);
        vec++;
        if (q.size() != 0 || busy || proto_err) begin
            errs++;
            $display("FAIL fwd_end pending=%0d busy=%b err=%b required=0 0 0", q.size(), busy, proto_err);
        end
        q.delete();
    endtask
    task automatic test_mask();
        tile_value = {4'b0000, 4'b0000, 4'b0100, 4'b0001};
        col_mask   = 4'b1000;
        drive(4'b0000, 4'b0000, 1, 0, 6'b000001, 3);
        drive(4'b0001, 4'b0000, 0, 0, 6'b000010, 3);
        vec++;
        if (occupiedmask !== 4'b1001) begin
            errs++;
            $display("FAIL mask_idx1 got=%b required=1001", occupiedmask);
        end
        drive(4'b0010, 4'b0000, 0, 0, 6'b000100, 3);
        vec++;
        if (occupiedmask !== 4'b1101 || cur_index !== 2'd2) begin
            errs++;
            $display("FAIL mask_idx2 got=%b idx=%0d required=1101 idx=2", occupiedmask, cur_index);
        end
        col_mask   = 4'b0000;
        tile_value = 16'hffff;
        step(5);
        vec++;
        if (occupiedmask !== 4'b1101) begin
            errs++;
            $display("FAIL mask_hold got=%b required=1101", occupiedmask);
        end
        tile_value = '0;
        drive(4'b0100, 4'b0000, 0, 0, 6'b001000, 3);
        drive(4'b1000, 4'b0000, 0, 0, 6'b100000, 4);
        vec++;
        if (q.size() != 0 || busy) begin
            errs++;
            $display("FAIL mask_end pending=%0d busy=%b required=0 0", q.size(), busy);
        end
        q.delete();
    endtask
    task automatic test_backtrack();
        drive(4'b0000, 4'b0000, 0, 1, 6'b001000, 3);
        drive(4'b0000, 4'b1000, 0, 0, 6'b000100, 3);
        drive(4'b0000, 4'b0100, 0, 0, 6'b000010, 3);
        drive(4'b0000, 4'b0010, 0, 0, 6'b000001, 3);
        drive(4'b0000, 4'b0001, 0, 0, 6'b010000, 4);
        vec++;
        if (q.size() != 0 || busy || proto_err || cur_index !== 2'd0) begin
            errs++;
            $display("FAIL bak_end pending=%0d busy=%b err=%b idx=%0d required=0 0 0 0",
                     q.size(), busy, proto_err, cur_index);
        end
        q.delete();
    endtask
    task automatic test_errors();
        do_reset();
        drive(4'b0000, 4'b0000, 1, 0, 6'b000001, 3);
        drive(4'b0001, 4'b0000, 0, 0, 6'b000010, 3);
        drive(4'b0100, 4'b0000, 0, 0, 6'b000000, 3);
        vec++;
        if (!proto_err || cur_index !== 2'd1 || !busy) begin
            errs++;
            $display("FAIL err_stray got err=%b idx=%0d required err=1 idx=1", proto_err, cur_index);
        end
        do_reset();
        drive(4'b0000, 4'b0000, 1, 0, 6'b000001, 3);
        drive(4'b0001, 4'b0000, 0, 0, 6'b000010, 3);
        vec++;
        if (proto_err) begin
            errs++;
            $display("FAIL err_clean got err=%b required=0", proto_err);
        end
        drive(4'b0010, 4'b0010, 0, 0, 6'b000001, 3);
        vec++;
        if (!proto_err || cur_index !== 2'd0) begin
            errs++;
            $display("FAIL err_both got err=%b idx=%0d required err=1 idx=0", proto_err, cur_index);
        end
        do_reset();
        drive(4'b0000, 4'b0000, 1, 0, 6'b000001, 0);
        drive(4'b0000, 4'b0000, 1, 0, 6'b000000, 3);
        vec++;
        if (!proto_err || cur_index !== 2'd0) begin
            errs++;
            $display("FAIL err_busy_start got err=%b idx=%0d required err=1 idx=0", proto_err, cur_index);
        end
        drive(4'b0001, 4'b0000, 0, 0, 6'b000010, 3);
        do_reset();
        drive(4'b0000, 4'b0000, 1, 1, 6'b001000, 3);
        vec++;
        if (!proto_err || cur_index !== 2'd3) begin
            errs++;
            $display("FAIL err_dual_start got err=%b idx=%0d required err=1 idx=3", proto_err, cur_index);
        end
        vec++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL err_leftover pending=%0d required=0", q.size());
        end
        q.delete();
    endtask
    task automatic test_timeout();
        do_reset();
        drive(4'b0000, 4'b0000, 1, 0, 6'b000001, 3);
        step(8);
        vec++;
        if (stall) begin
            errs++;
            $display("FAIL stall_early got=%b required=0", stall);
        end
        step(12);
        vec++;
        if (!stall || !busy || cur_index !== 2'd0 || proto_err) begin
            errs++;
            $display("FAIL stall_set got stall=%b busy=%b idx=%0d err=%b required 1 1 0 0",
                     stall, busy, cur_index, proto_err);
        end
        drive(4'b0001, 4'b0000, 0, 0, 6'b000010, 3);
        vec++;
        if (!stall || cur_index !== 2'd1 || q.size() != 0) begin
            errs++;
            $display("FAIL stall_after got stall=%b idx=%0d pending=%0d required 1 1 0",
                     stall, cur_index, q.size());
        end
        q.delete();
    endtask
    initial begin
        test_reset();
        test_forward();
        test_mask();
        test_backtrack();
        test_errors();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
